// File: rtl/dpd_pkg.sv
// -----------------------------------------------------------------------------
// dpd_pkg
//   Definitions shared by the DPD datapath blocks (input_buffer, output_buffer):
//   default datapath widths, the Q1.15 rail values and the I/Q sample record.
// -----------------------------------------------------------------------------
package dpd_pkg;

    localparam int DPD_DATA_WIDTH = 16;
    localparam int DPD_ACC_WIDTH  = 32;

    localparam logic [DPD_DATA_WIDTH-1:0] Q15_MAX = 16'h7FFF;
    localparam logic [DPD_DATA_WIDTH-1:0] Q15_MIN = 16'h8000;

    typedef struct packed {
        logic signed [DPD_DATA_WIDTH-1:0] i;
        logic signed [DPD_DATA_WIDTH-1:0] q;
    } iq_sample_t;

endpackage

// File: rtl/iq_fifo.sv
// -----------------------------------------------------------------------------
// iq_fifo
//   Synchronous show-ahead FIFO. The head entry is presented on o_rd_data
//   whenever o_valid is high; when empty, o_rd_data holds the last popped word.
//   Simultaneous write and read is accepted even when full.
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   i_wr_en       write request (ignored when full unless a read pops the head)
//   i_wr_data     word to store
//   i_rd_en       pop request (ignored when empty)
//   o_rd_data     head word / last popped word
//   o_valid       FIFO not empty
//   o_level       number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module iq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_last;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_pop   = i_rd_en && !w_empty;
    // A write into a full FIFO is legal when the head leaves in the same cycle.
    assign w_push  = i_wr_en && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr];
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Empty FIFO keeps showing the most recently popped word.
    assign o_rd_data = w_empty ? r_last : r_mem[r_rd_ptr];
    assign o_valid   = !w_empty;
    assign o_level   = r_level;

endmodule

// File: rtl/output_buffer.sv
// -----------------------------------------------------------------------------
// output_buffer
//   DPD back end: rounds/saturates the NN accumulator I/Q pair to Q1.15 in one
//   registered stage and queues it in a show-ahead FIFO feeding the DAC stream.
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   nn_i, nn_q        accumulator-format I/Q, qualified by nn_valid
//   nn_valid/ready    input handshake; nn_ready depends on registered state only
//   out_i, out_q      Q1.15 head sample, qualified by out_valid
//   out_ready         DAC consumes the head sample
//   fifo_level        entries currently stored in the FIFO
//   sat_flag          pulse: the stage register holds a clipped sample
//   sat_count         clipped-sample counter (zero unless SAT_COUNT_EN)
// Configuration
//   SAT_COUNT_EN      when defined, sat_count counts clipped samples and
//                     sticks at all-ones; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module output_buffer
    import dpd_pkg::*;
#(
    parameter int DATA_WIDTH    = DPD_DATA_WIDTH,
    parameter int ACC_WIDTH     = DPD_ACC_WIDTH,
    parameter int FRAC_SHIFT    = 15,
    parameter int FIFO_DEPTH    = 8,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ACC_WIDTH-1:0]          nn_i,
    input  logic [ACC_WIDTH-1:0]          nn_q,
    input  logic                          nn_valid,
    output logic                          nn_ready,
    output logic [DATA_WIDTH-1:0]         out_i,
    output logic [DATA_WIDTH-1:0]         out_q,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          sat_flag,
    output logic [SAT_CNT_WIDTH-1:0]      sat_count
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int FW    = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH:0] RND_HALF =
        {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_HI =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_LO =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Round half up with one guard bit so the +half cannot overflow.
    function automatic logic signed [ACC_WIDTH:0] round_acc(
        input logic signed [ACC_WIDTH-1:0] x
    );
        logic signed [ACC_WIDTH:0] sum;
        sum = {x[ACC_WIDTH-1], x} + RND_HALF;
        return sum >>> FRAC_SHIFT;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [DATA_WIDTH:0] sat_q15(
        input logic signed [ACC_WIDTH:0] r
    );
        if (r > SAT_HI) begin
            return {1'b1, SAT_POS};
        end else if (r < SAT_LO) begin
            return {1'b1, SAT_NEG};
        end
        return {1'b0, r[DATA_WIDTH-1:0]};
    endfunction

    logic                  w_accept;
    logic [DATA_WIDTH:0]   w_sat_i;
    logic [DATA_WIDTH:0]   w_sat_q;
    logic [LVL_W:0]        w_occupancy;
    logic [FW-1:0]         w_head;

    logic [FW-1:0]         r_data_p1;
    logic                  r_vld_p1;
    logic                  r_clip_p1;

    assign w_sat_i  = sat_q15(round_acc($signed(nn_i)));
    assign w_sat_q  = sat_q15(round_acc($signed(nn_q)));

    // Count the sample in the stage register so the FIFO can never overflow.
    assign w_occupancy = {1'b0, fifo_level} + (LVL_W+1)'(r_vld_p1);
    assign nn_ready    = (w_occupancy < (LVL_W+1)'(FIFO_DEPTH));
    assign w_accept    = nn_valid && nn_ready;

    // ---- stage 1: round/saturate into the stage register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_clip_p1 <= 1'b0;
        end else begin
            r_vld_p1  <= w_accept;
            r_clip_p1 <= w_accept && (w_sat_i[DATA_WIDTH] || w_sat_q[DATA_WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data_p1 <= {w_sat_i[DATA_WIDTH-1:0], w_sat_q[DATA_WIDTH-1:0]};
        end
    end

    assign sat_flag = r_clip_p1;

    // ---- stage 2: push into the show-ahead FIFO ----
    iq_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (r_vld_p1),
        .i_wr_data (r_data_p1),
        .i_rd_en   (out_ready),
        .o_rd_data (w_head),
        .o_valid   (out_valid),
        .o_level   (fifo_level)
    );

    assign out_i = w_head[FW-1:DATA_WIDTH];
    assign out_q = w_head[DATA_WIDTH-1:0];

`ifdef SAT_COUNT_EN
    logic [SAT_CNT_WIDTH-1:0] r_sat_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (r_clip_p1 && (r_sat_count != '1)) begin
            r_sat_count <= r_sat_count + 1'b1;
        end
    end

    assign sat_count = r_sat_count;
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_output_buffer.sv
module tb_output_buffer;
    import dpd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] nn_i = '0;
    logic [31:0] nn_q = '0;
    logic        nn_valid = 1'b0;
    logic        nn_ready;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  fifo_level;
    logic        sat_flag;
    logic [15:0] sat_count;

    int n_err = 0;
    int n_chk = 0;
    int n_clip = 0;   // clipped samples written since the last reset

    output_buffer #(
        .DATA_WIDTH    (16),
        .ACC_WIDTH     (32),
        .FRAC_SHIFT    (15),
        .FIFO_DEPTH    (8),
        .SAT_CNT_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .nn_i       (nn_i),
        .nn_q       (nn_q),
        .nn_valid   (nn_valid),
        .nn_ready   (nn_ready),
        .out_i      (out_i),
        .out_q      (out_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .sat_flag   (sat_flag),
        .sat_count  (sat_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: floor((x + 2^14) / 2^15) clipped to the Q1.15 range; returns {clip, value}.
    function automatic logic [16:0] ref_conv(input logic [31:0] x);
        longint v;
        v = longint'($signed(x));
        v = (v + 64'sd16384) >>> 15;
        if (v > 32767)  return {1'b1, Q15_MAX};
        if (v < -32768) return {1'b1, Q15_MIN};
        return {1'b0, v[15:0]};
    endfunction

    function automatic logic [31:0] rand_acc();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($signed($urandom) >>> $urandom_range(8, 16));
            2:       return 32'(int'($urandom_range(0, 65535)) - 32768);
            default: return {($urandom_range(0, 1) == 1) ? 16'h3FFF : 16'hC000, 16'($urandom)};
        endcase
    endfunction

    function automatic int exp_sat_count(input int clips);
`ifdef SAT_COUNT_EN
        return (clips > 65535) ? 65535 : clips;
`else
        return 0 * clips;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        nn_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_chk++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        n_chk++; if ({out_i, out_q} !== 32'h0) begin n_err++; $display("FAIL reset_out got=%h exp=0", {out_i, out_q}); end
        n_chk++; if (sat_flag !== 1'b0 || sat_count !== 16'd0) begin n_err++; $display("FAIL reset_sat got=%0b/%0d exp=0/0", sat_flag, sat_count); end
        rst = 1'b0;
        n_clip = 0;
        tick();
        n_chk++; if (nn_ready !== 1'b1) begin n_err++; $display("FAIL reset_nn_ready got=%0b exp=1", nn_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        nn_i = 32'h2000_0000;
        nn_q = 32'hE000_0000;
        nn_valid = 1'b1;
        tick();
        nn_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0 || sat_flag !== 1'b0) begin n_err++; $display("FAIL single_lat1 got vld=%0b sat=%0b exp 0/0", out_valid, sat_flag); end
        tick();
        n_chk++; if (out_valid !== 1'b1 || out_i !== 16'h4000 || out_q !== 16'hC000)
            begin n_err++; $display("FAIL single_out got vld=%0b %h/%h exp 1 4000/c000", out_valid, out_i, out_q); end
        tick();
        n_chk++; if (out_valid !== 1'b0 || out_i !== 16'h4000 || out_q !== 16'hC000)
            begin n_err++; $display("FAIL single_hold got vld=%0b %h/%h exp 0 4000/c000", out_valid, out_i, out_q); end
    endtask

    task automatic test_rounding();
        logic [31:0] vin [3];
        logic [15:0] vexp [3];
        vin[0] = 32'h0000_4000; vexp[0] = 16'h0001;
        vin[1] = 32'h0000_3FFF; vexp[1] = 16'h0000;
        vin[2] = 32'hFFFF_C000; vexp[2] = 16'h0000;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nn_i = vin[k];
            nn_q = 32'h0;
            nn_valid = 1'b1;
            tick();
            nn_valid = 1'b0;
            tick();
            n_chk++; if (out_valid !== 1'b1 || out_i !== vexp[k])
                begin n_err++; $display("FAIL round_%0d got vld=%0b %h exp 1 %h", k, out_valid, out_i, vexp[k]); end
        end
        tick();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        nn_i = 32'h4000_0000;
        nn_q = 32'hBFFF_0000;
        nn_valid = 1'b1;
        tick();
        nn_valid = 1'b0;
        n_clip++;
        n_chk++; if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat_flag_on got=%0b exp=1", sat_flag); end
        tick();
        n_chk++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL sat_flag_off got=%0b exp=0", sat_flag); end
        n_chk++; if (out_i !== 16'h7FFF || out_q !== 16'h8000) begin n_err++; $display("FAIL sat_out got=%h/%h exp 7fff/8000", out_i, out_q); end
        n_chk++; if (int'(sat_count) != exp_sat_count(n_clip)) begin n_err++; $display("FAIL sat_count got=%0d exp=%0d", sat_count, exp_sat_count(n_clip)); end
        tick();
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int got = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            nn_valid = 1'b1;
            nn_i = (acc + 1) << 15;
            nn_q = -((acc + 1) << 15);
            if (nn_ready) acc++;
            tick();
        end
        nn_valid = 1'b0;
        tick();
        n_chk++; if (acc != 8) begin n_err++; $display("FAIL bp_accepted got=%0d exp=8", acc); end
        n_chk++; if (nn_ready !== 1'b0 || fifo_level !== 4'd8) begin n_err++; $display("FAIL bp_full got rdy=%0b lvl=%0d exp 0/8", nn_ready, fifo_level); end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                n_chk++; if (out_i !== 16'(got + 1) || out_q !== 16'(-(got + 1)))
                    begin n_err++; $display("FAIL bp_order_%0d got=%h/%h exp %h/%h", got, out_i, out_q, 16'(got + 1), 16'(-(got + 1))); end
                got++;
            end
            tick();
        end
        n_chk++; if (got != 8 || fifo_level !== 4'd0) begin n_err++; $display("FAIL bp_drain got=%0d lvl=%0d exp 8/0", got, fifo_level); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] vi, vq;
        logic [16:0] ei, eq;
        bit seen = 0;
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            nn_i = rand_acc();
            nn_q = rand_acc();
            nn_valid = 1'b1;
            tick();
        end
        nn_valid = 1'b0;
        tick();
        tick();
        n_chk++; if (fifo_level !== 4'd5) begin n_err++; $display("FAIL mrst_level5 got=%0d exp=5", fifo_level); end
        #3;
        rst = 1'b1;
        #1;
        n_chk++; if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin n_err++; $display("FAIL mrst_async got vld=%0b lvl=%0d exp 0/0", out_valid, fifo_level); end
        n_chk++; if ({out_i, out_q} !== 32'h0) begin n_err++; $display("FAIL mrst_out got=%h exp=0", {out_i, out_q}); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_clip = 0;
        n_chk++; if (sat_count !== 16'd0) begin n_err++; $display("FAIL mrst_sat_count got=%0d exp=0", sat_count); end
        vi = rand_acc();
        vq = rand_acc();
        ei = ref_conv(vi);
        eq = ref_conv(vq);
        nn_i = vi;
        nn_q = vq;
        nn_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        nn_valid = 1'b0;
        if (ei[16] || eq[16]) n_clip++;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (out_valid) begin
                seen = 1;
                n_chk++; if (out_i !== ei[15:0] || out_q !== eq[15:0])
                    begin n_err++; $display("FAIL mrst_first got=%h/%h exp %h/%h", out_i, out_q, ei[15:0], eq[15:0]); end
            end
            tick();
        end
        n_chk++; if (!seen) begin n_err++; $display("FAIL mrst_timeout got=no output exp=output within 10 cycles"); end
        n_chk++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL mrst_empty got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_streaming();
        iq_sample_t exp_q [$];
        iq_sample_t e;
        logic [16:0] ci, cq;
        bit prev_clip = 0;
        int acc = 0, pops = 0, hit_full = 0, hit_one = 0, cyc = 0, bad = 0;
        while (acc < 1000 && cyc < 20000) begin
            if (sat_flag !== prev_clip) begin bad++; $display("FAIL stream_sat_flag cyc=%0d got=%0b exp=%0b", cyc, sat_flag, prev_clip); end
            if (fifo_level > 4'd8 || (fifo_level == 4'd8 && nn_ready)) begin bad++; $display("FAIL stream_level cyc=%0d got lvl=%0d rdy=%0b exp lvl<=8, rdy=0 at 8", cyc, fifo_level, nn_ready); end
            if (acc < 600) begin
                nn_valid  = ($urandom_range(0, 1) == 1);
                out_ready = ($urandom_range(0, 1) == 1);
            end else begin
                nn_valid  = ($urandom_range(0, 9) != 0);
                out_ready = ($urandom_range(0, 4) == 0);
            end
            nn_i = rand_acc();
            nn_q = rand_acc();
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL stream_extra got=%h/%h exp=no output", out_i, out_q);
                end else begin
                    e = exp_q.pop_front();
                    if (out_i !== e.i || out_q !== e.q) begin bad++; $display("FAIL stream_data pop=%0d got=%h/%h exp %h/%h", pops, out_i, out_q, e.i, e.q); end
                end
                if (fifo_level == 4'd8) hit_full++;
                if (fifo_level == 4'd1) hit_one++;
                pops++;
            end
            prev_clip = 0;
            if (nn_valid && nn_ready) begin
                ci = ref_conv(nn_i);
                cq = ref_conv(nn_q);
                exp_q.push_back('{i: ci[15:0], q: cq[15:0]});
                prev_clip = ci[16] | cq[16];
                if (prev_clip) n_clip++;
                acc++;
            end
            tick();
            cyc++;
        end
        nn_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
            if (sat_flag !== prev_clip) begin bad++; $display("FAIL stream_sat_flag_drain got=%0b exp=%0b", sat_flag, prev_clip); end
            prev_clip = 0;
            if (out_valid) begin
                e = exp_q.pop_front();
                if (out_i !== e.i || out_q !== e.q) begin bad++; $display("FAIL stream_data pop=%0d got=%h/%h exp %h/%h", pops, out_i, out_q, e.i, e.q); end
                pops++;
            end
            tick();
        end
        n_chk++; if (bad != 0) begin n_err++; $display("FAIL stream_checks got=%0d bad cycles exp=0", bad); end
        n_chk++; if (acc != 1000 || exp_q.size() != 0) begin n_err++; $display("FAIL stream_count got acc=%0d left=%0d exp 1000/0", acc, exp_q.size()); end
        n_chk++; if (pops != 1000 || out_valid !== 1'b0) begin n_err++; $display("FAIL stream_pops got=%0d vld=%0b exp 1000/0", pops, out_valid); end
        n_chk++; if (hit_full == 0 || hit_one == 0) begin n_err++; $display("FAIL stream_corners got full=%0d one=%0d exp both >0", hit_full, hit_one); end
        n_chk++; if (int'(sat_count) != exp_sat_count(n_clip)) begin n_err++; $display("FAIL stream_sat_count got=%0d exp=%0d", sat_count, exp_sat_count(n_clip)); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_mid_reset();
        test_streaming();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
